mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester memory arbiter for the d16 core. It shares one synchronous single-port memory between the instruction-fetch unit and the load/store unit. Each requester uses a req/ack handshake, and the arbiter sequences every access through a fixed-latency memory port. Data accesses win contention by default, and a starvation counter guarantees that fetch makes forward progress.

## Interface
Parameters:
- ADDR_WIDTH, 16: address width of all ports.
- DATA_WIDTH, 16: data width of all ports.
- MEM_LATENCY, 1: cycles from mem_en to valid mem_rdata; legal range 1..7.
- STARVE_LIMIT, 3: consecutive contested data grants before fetch is forced; legal range 0..7, 0 = fetch always wins contention.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- i_req  in  1  fetch request; held with i_addr stable until i_ack.
- i_addr  in  ADDR_WIDTH  fetch address.
- i_rdata  out  DATA_WIDTH  fetch read data; registered, valid while i_ack=1.
- i_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  write data.
- d_rdata  out  DATA_WIDTH  data read data; registered, valid while d_ack=1.
- d_ack  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory access strobe, exactly one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_WIDTH  memory address, held for the whole access.
- mem_wdata  out  DATA_WIDTH  memory write data, held for the whole access.
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en.
- busy  out  1  high in every state except IDLE.

## Operation
- State machine states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Requests are sampled only here.
  - No request: remain in IDLE.
  - Otherwise select a winner, latch owner, we, addr and wdata into the mem_* registers, and go to ISSUE.
- **Arbitration in IDLE**
  - Only one req high: that requester wins.
  - Both high and starve_cnt < STARVE_LIMIT: data wins.
  - Both high and starve_cnt == STARVE_LIMIT: fetch wins.
- **starve_cnt** is 3 bits.
  - Increments when data wins while i_req=1.
  - Clears when fetch wins, or in IDLE when i_req=0.
  - Never exceeds STARVE_LIMIT.
- **ISSUE:** mem_en=1 for this cycle only; load wait counter with MEM_LATENCY; go to WAIT.
- **WAIT**
  - Counter decrements each cycle.
  - At the edge ending the cycle where the counter equals 1, capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
- **DONE**
  - Assert the owner's ack for exactly one cycle; the other ack stays 0.
  - Return to IDLE.
- **Writes** follow the same sequence. d_rdata is unchanged by writes. Fetch is read-only; mem_we=0 for fetch grants.
- **rdata persistence:** i_rdata and d_rdata hold their last captured values until the next read by the same owner.
- **Dropped request:** if a requester drops req mid-access, the access still completes and ack still pulses. A requester that no longer wants the access ignores the ack.
- **Back-to-back requests:** a requester drops req on the edge where it sees ack, or keeps it high to request again. A req still high in the following IDLE cycle is a new request.
- **Async reset (rst=0)**, including mid-access:
  - State → IDLE; counters → 0.
  - mem_en, mem_we, i_ack, d_ack, busy → 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata → 0.
  - The aborted access is never acked.

## Timing
- Request sampled in IDLE at cycle t:
  - ISSUE at t+1.
  - WAIT from t+2 to t+1+MEM_LATENCY.
  - DONE/ack at t+2+MEM_LATENCY.
- Request-to-ack latency: MEM_LATENCY+2 cycles after the sampling cycle. With MEM_LATENCY=1, ack arrives 3 cycles after the sampling cycle.
- One access per MEM_LATENCY+3 cycles; accesses never overlap.
- mem_addr, mem_we and mem_wdata are stable from ISSUE through DONE and change only when leaving IDLE.
- All outputs are registered; there are no combinational paths from any input to any output.

## Test plan
- **Single fetch** (MEM_LATENCY=1, memory[0x0010]=0xBEEF): i_req with i_addr=0x0010 sampled at cycle t → mem_en=1 only at t+1, i_ack=1 only at t+3, i_rdata=0xBEEF, d_ack stays 0.
- **Data write then read:** write 0x1234 to 0x0200 → mem_we=1 with mem_en, d_ack pulse, d_rdata unchanged. Then read 0x0200 → d_rdata=0x1234 with d_ack.
- **Contention** (STARVE_LIMIT=3, i_req and d_req both held high continuously) → grant order D,D,D,I,D,D,D,I; starve_cnt never exceeds 3. Repeat with STARVE_LIMIT=0 → fetch wins every contested arbitration.
- **Latency sweep:** MEM_LATENCY=3, data read → ack exactly 5 cycles after the sampling cycle. The memory model drives garbage except in the valid cycle, and d_rdata must equal the valid-cycle value.
- **Reset mid-access:** assert rst=0 during WAIT → outputs go to 0 asynchronously before the next clock edge, no ack follows. After release with i_req=1, a normal fetch completes.
- **Withdrawn request:** d_req dropped in the ISSUE cycle → d_ack still pulses once. Next IDLE with no req → busy=0, mem_en stays 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the load/store port and the
// memory port of the d16 memory arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives acks, rdata,
//            mem_* strobes and busy)
//   master : environment view (requesters plus memory)
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   // fetch port
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [DATA_WIDTH-1:0] i_rdata;
   logic                  i_ack;
   // load/store port
   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic [DATA_WIDTH-1:0] d_rdata;
   logic                  d_ack;
   // memory port
   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   // status
   logic                  busy;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr,
             mem_wdata, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr,
             mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port memory between the fetch
// unit and the load/store unit. Requests are sampled only in IDLE; each
// access runs IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> DONE. Data wins
// contention unless fetch has lost STARVE_LIMIT contested grants in a row.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - mem_arbiter_if.slave: fetch req/ack, data req/ack, memory port,
//          busy. All outputs are registered.
module mem_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 16,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 3
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [2:0] LAT  = 3'(MEM_LATENCY);
   localparam logic [2:0] SLIM = 3'(STARVE_LIMIT);

   state_t                state, state_nx;
   logic [2:0]            wcnt, wcnt_nx;
   logic [2:0]            starve_cnt, starve_nx;
   logic                  grant_i, grant_d;
   logic                  cap;
   logic                  owner_d;     // 1 = current access belongs to data port
   logic                  mem_en_q, mem_en_nx;
   logic                  i_ack_q, i_ack_nx;
   logic                  d_ack_q, d_ack_nx;
   logic                  busy_q, busy_nx;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      wcnt_nx   = wcnt;
      starve_nx = starve_cnt;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      cap       = 1'b0;
      mem_en_nx = 1'b0;
      i_ack_nx  = 1'b0;
      d_ack_nx  = 1'b0;
      case (state)
         IDLE: begin
            // data wins unless fetch is also asking and has hit the limit
            if (bus.d_req && (!bus.i_req || starve_cnt < SLIM)) grant_d = 1'b1;
            else if (bus.i_req)                                 grant_i = 1'b1;
            // count only grants that actually made fetch wait
            if (grant_d && bus.i_req)       starve_nx = starve_cnt + 3'd1;
            else if (grant_i || !bus.i_req) starve_nx = 3'd0;
            if (grant_i || grant_d) begin
               state_nx  = ISSUE;
               mem_en_nx = 1'b1;        // registered, so high during ISSUE
            end
         end
         ISSUE: begin
            state_nx = WAIT;
            wcnt_nx  = LAT;
         end
         WAIT: begin
            wcnt_nx = wcnt - 3'd1;
            if (wcnt == 3'd1) begin
               state_nx = DONE;
               cap      = 1'b1;
               i_ack_nx = !owner_d;
               d_ack_nx = owner_d;
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt        <= '0;
         starve_cnt  <= '0;
         owner_d     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         busy_q      <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         wcnt       <= wcnt_nx;
         starve_cnt <= starve_nx;
         mem_en_q   <= mem_en_nx;
         i_ack_q    <= i_ack_nx;
         d_ack_q    <= d_ack_nx;
         busy_q     <= busy_nx;
         // memory command is latched only when leaving IDLE and held after
         if (grant_i || grant_d) begin
            owner_d     <= grant_d;
            mem_we_q    <= grant_d && bus.d_we;
            mem_addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
            mem_wdata_q <= grant_d ? bus.d_wdata : '0;
         end
         if (cap && !mem_we_q) begin
            if (owner_d) d_rdata_q <= bus.mem_rdata;
            else         i_rdata_q <= bus.mem_rdata;
         end
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.i_ack     = i_ack_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiter instances (u0: MEM_LATENCY=1, STARVE_LIMIT=3;
// u1: MEM_LATENCY=3, STARVE_LIMIT=0), each with a memory model. Stimulus
// pushes expected acks into a per-instance queue; a monitor per instance
// pops and compares on every ack.
module tb_mem_arbiter;
   typedef struct {
      bit          own;     // 1 = data port
      bit          we;
      logic [15:0] addr;
      logic [15:0] rdata;
      int          cyc;     // cycle in which the ack must be seen
   } exp_t;

   logic        clk = 1'b0;
   logic [1:0]  rst;
   logic [1:0]  i_req, d_req, d_we;
   logic [15:0] i_addr [2];
   logic [15:0] d_addr [2];
   logic [15:0] d_wdata [2];
   logic [1:0]  i_ack_o, d_ack_o, mem_en_o, mem_we_o, busy_o;
   logic [15:0] i_rdata_o [2];
   logic [15:0] d_rdata_o [2];
   logic [15:0] mem_addr_o [2];
   logic [15:0] mem_wdata_o [2];

   exp_t sbq [2][$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_u
         localparam int LAT = (g == 0) ? 1 : 3;
         localparam int SL  = (g == 0) ? 3 : 0;

         mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

         mem_arbiter #(
            .ADDR_WIDTH(16), .DATA_WIDTH(16),
            .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)
         ) u_dut (
            .clk (clk),
            .rst (rst[g]),
            .bus (bus)
         );

         assign bus.i_req       = i_req[g];
         assign bus.i_addr      = i_addr[g];
         assign bus.d_req       = d_req[g];
         assign bus.d_we        = d_we[g];
         assign bus.d_addr      = d_addr[g];
         assign bus.d_wdata     = d_wdata[g];
         assign i_ack_o[g]      = bus.i_ack;
         assign d_ack_o[g]      = bus.d_ack;
         assign mem_en_o[g]     = bus.mem_en;
         assign mem_we_o[g]     = bus.mem_we;
         assign busy_o[g]       = bus.busy;
         assign i_rdata_o[g]    = bus.i_rdata;
         assign d_rdata_o[g]    = bus.d_rdata;
         assign mem_addr_o[g]   = bus.mem_addr;
         assign mem_wdata_o[g]  = bus.mem_wdata;

         // memory: data valid only in the cycle LAT cycles after mem_en
         logic [15:0] mem [0:4095];
         logic [15:0] pdata = 16'h0;
         int          pcnt = 0;
         always @(posedge clk) begin
            if (!rst[g]) begin
               for (int i = 0; i < 4096; i++) mem[i] <= 16'h0;
               mem[12'h010] <= 16'hBEEF;
               mem[12'h300] <= 16'h5A5A;
               pcnt <= 0;
            end else if (bus.mem_en) begin
               pdata <= mem[bus.mem_addr[11:0]];
               if (bus.mem_we) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
               pcnt <= LAT;
            end else if (pcnt != 0) pcnt <= pcnt - 1;
         end
         assign bus.mem_rdata = (pcnt == 1) ? pdata : 16'hDEAD;

         // monitor
         exp_t        e;
         int          mcnt = 0;
         int          mcyc = 0;
         logic        mwe = 1'b0;
         logic [15:0] maddr = 16'h0;
         always @(negedge clk) begin
            if (!rst[g]) mcnt = 0;
            else begin
               if (bus.mem_en) begin
                  mcnt++;
                  mcyc  = cyc;
                  mwe   = bus.mem_we;
                  maddr = bus.mem_addr;
               end
               if (bus.i_ack || bus.d_ack) begin
                  chk($sformatf("u%0d ack exclusive", g), 32'(bus.i_ack & bus.d_ack), 32'd0);
                  chk($sformatf("u%0d ack expected", g), 32'(sbq[g].size() > 0), 32'd1);
                  if (sbq[g].size() > 0) begin
                     e = sbq[g].pop_front();
                     chk($sformatf("u%0d ack owner", g), 32'(bus.d_ack), 32'(e.own));
                     chk($sformatf("u%0d ack cycle", g), cyc, e.cyc);
                     chk($sformatf("u%0d rdata", g),
                         32'(e.own ? bus.d_rdata : bus.i_rdata), 32'(e.rdata));
                     chk($sformatf("u%0d mem_en pulses", g), mcnt, 32'd1);
                     chk($sformatf("u%0d mem_en cycle", g), mcyc, e.cyc - LAT - 1);
                     chk($sformatf("u%0d mem_we", g), 32'(mwe), 32'(e.we));
                     chk($sformatf("u%0d mem_addr issue", g), 32'(maddr), 32'(e.addr));
                     chk($sformatf("u%0d mem_addr done", g), 32'(bus.mem_addr), 32'(e.addr));
                  end
                  mcnt = 0;
               end
            end
         end
      end
   endgenerate

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(int u, bit own, bit we, logic [15:0] a, logic [15:0] rd, int c);
      exp_t e;
      e.own = own; e.we = we; e.addr = a; e.rdata = rd; e.cyc = c;
      sbq[u].push_back(e);
   endtask

   task automatic wait_idle(int u);
      int n = 0;
      while (busy_o[u] && n < 30) begin step(1); n++; end
      if (n >= 30) begin
         n_cmp++; n_err++;
         $display("FAIL u%0d idle timeout", u);
      end
   endtask

   task automatic wait_ack(int u);
      int n = 0;
      while (!(i_ack_o[u] || d_ack_o[u]) && n < 30) begin step(1); n++; end
      if (n >= 30) begin
         n_cmp++; n_err++;
         $display("FAIL u%0d ack timeout", u);
      end
   endtask

   // one access issued in an IDLE cycle; req dropped in the ack cycle
   task automatic access(int u, bit own, bit we, logic [15:0] a,
                         logic [15:0] wd, logic [15:0] rd);
      wait_idle(u);
      push(u, own, we, a, rd, cyc + ((u == 0) ? 1 : 3) + 2);
      if (own) begin
         d_req[u] = 1'b1; d_we[u] = we; d_addr[u] = a; d_wdata[u] = wd;
      end else begin
         i_req[u] = 1'b1; i_addr[u] = a;
      end
      wait_ack(u);
      i_req[u] = 1'b0;
      d_req[u] = 1'b0;
   endtask

   task automatic chk_zero(int u, string nm);
      chk($sformatf("u%0d %s mem_en", u, nm),    32'(mem_en_o[u]), 32'd0);
      chk($sformatf("u%0d %s mem_we", u, nm),    32'(mem_we_o[u]), 32'd0);
      chk($sformatf("u%0d %s i_ack", u, nm),     32'(i_ack_o[u]), 32'd0);
      chk($sformatf("u%0d %s d_ack", u, nm),     32'(d_ack_o[u]), 32'd0);
      chk($sformatf("u%0d %s busy", u, nm),      32'(busy_o[u]), 32'd0);
      chk($sformatf("u%0d %s mem_addr", u, nm),  32'(mem_addr_o[u]), 32'd0);
      chk($sformatf("u%0d %s mem_wdata", u, nm), 32'(mem_wdata_o[u]), 32'd0);
      chk($sformatf("u%0d %s i_rdata", u, nm),   32'(i_rdata_o[u]), 32'd0);
      chk($sformatf("u%0d %s d_rdata", u, nm),   32'(d_rdata_o[u]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst = 2'b00; i_req = '0; d_req = '0; d_we = '0;
      for (int u = 0; u < 2; u++) begin
         i_addr[u] = '0; d_addr[u] = '0; d_wdata[u] = '0;
      end
      step(2);
      chk_zero(0, "reset");
      chk_zero(1, "reset");
      rst = 2'b11;
      step(2);
      chk("u0 idle busy", 32'(busy_o[0]), 32'd0);
      chk("u0 idle mem_en", 32'(mem_en_o[0]), 32'd0);

      // u0: fetch, data write, data read
      access(0, 1'b0, 1'b0, 16'h0010, 16'h0, 16'hBEEF);
      access(0, 1'b1, 1'b1, 16'h0200, 16'h1234, 16'h0000);
      access(0, 1'b1, 1'b0, 16'h0200, 16'h0, 16'h1234);

      // u0: data request withdrawn in the ISSUE cycle still completes
      wait_idle(0);
      push(0, 1'b1, 1'b0, 16'h0200, 16'h1234, cyc + 3);
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0200;
      step(1);
      d_req[0] = 1'b0;
      wait_ack(0);
      step(1);
      for (int k = 0; k < 3; k++) begin
         chk("u0 withdrawn busy", 32'(busy_o[0]), 32'd0);
         chk("u0 withdrawn mem_en", 32'(mem_en_o[0]), 32'd0);
         step(1);
      end

      // u0: continuous contention, STARVE_LIMIT=3 -> D,D,D,I,D,D,D,I
      wait_idle(0);
      t0 = cyc;
      for (int k = 0; k < 8; k++) begin
         if ((k % 4) == 3) push(0, 1'b0, 1'b0, 16'h0010, 16'hBEEF, t0 + 4*k + 3);
         else              push(0, 1'b1, 1'b0, 16'h0200, 16'h1234, t0 + 4*k + 3);
      end
      i_req[0] = 1'b1; i_addr[0] = 16'h0010;
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0200;
      while (cyc < t0 + 31) step(1);
      i_req[0] = 1'b0; d_req[0] = 1'b0;

      // u0: reset during WAIT, then a normal fetch with i_req held
      wait_idle(0);
      i_req[0] = 1'b1; i_addr[0] = 16'h0010;
      step(2);
      #2 rst[0] = 1'b0;
      #1 chk_zero(0, "midreset");
      step(2);
      rst[0] = 1'b1;
      push(0, 1'b0, 1'b0, 16'h0010, 16'hBEEF, cyc + 3);
      wait_ack(0);
      i_req[0] = 1'b0;

      // u1: MEM_LATENCY=3 data read, ack 5 cycles after sampling
      access(1, 1'b1, 1'b0, 16'h0300, 16'h0, 16'h5A5A);

      // u1: STARVE_LIMIT=0 -> fetch wins every contested grant
      wait_idle(1);
      t0 = cyc;
      push(1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, t0 + 5);
      push(1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, t0 + 11);
      push(1, 1'b1, 1'b0, 16'h0300, 16'h5A5A, t0 + 17);
      i_req[1] = 1'b1; i_addr[1] = 16'h0010;
      d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 16'h0300;
      while (cyc < t0 + 11) step(1);
      i_req[1] = 1'b0;
      while (cyc < t0 + 17) step(1);
      d_req[1] = 1'b0;

      step(8);
      chk("u0 leftover expectations", sbq[0].size(), 32'd0);
      chk("u1 leftover expectations", sbq[1].size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
